// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUctrl operation codes and the execution-unit FSM states.
// The ALU control unit imports the same package so both sides agree on the encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations. Shift codes are handled iteratively by the parent,
// so here they simply produce zero without being flagged illegal.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       code,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;

    assign sum     = a + b;
    assign diff    = a - b;
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (code)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_ADD: begin
                result = sum;
                ovf    = ovf_add;
            end
            ALU_SUB: begin
                result = diff;
                ovf    = ovf_sub;
            end
            // The sign of the true difference is the raw sign bit corrected by overflow.
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
            ALU_SLL, ALU_SRL: result = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshakes: single-cycle ops finish in one cycle,
// SLL/SRL shift one bit per BUSY cycle, and results are held in DONE until consumed.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    state_t           state;
    state_t           state_next;
    logic [3:0]       code_q;
    logic [WIDTH-1:0] shift_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             illegal_q;

    logic [WIDTH-1:0] comb_result;
    logic             comb_ovf;
    logic             comb_illegal;
    logic             accept;
    logic             shift_req;
    logic [WIDTH-1:0] shift_step;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .a       (a),
        .b       (b),
        .code    (ALUctrl),
        .result  (comb_result),
        .ovf     (comb_ovf),
        .illegal (comb_illegal)
    );

    assign accept     = in_valid && (state == ST_IDLE);
    assign shift_req  = is_shift(ALUctrl);
    assign shift_step = (code_q == ALU_SLL) ? (shift_q << 1) : (shift_q >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length shift skips BUSY; otherwise leave BUSY on the edge that performs the last bit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (shift_req && (shamt != 5'd0)) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 5'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        code_q  <= ALUctrl;
                        shift_q <= b;
                        cnt_q   <= shamt;
                        if (shift_req) begin
                            if (shamt == 5'd0) begin
                                result_q  <= b;
                                zero_q    <= (b == '0);
                                ovf_q     <= 1'b0;
                                illegal_q <= 1'b0;
                            end
                        end else begin
                            result_q  <= comb_result;
                            zero_q    <= (comb_result == '0);
                            ovf_q     <= comb_ovf;
                            illegal_q <= comb_illegal;
                        end
                    end
                end
                ST_BUSY: begin
                    shift_q <= shift_step;
                    cnt_q   <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_q  <= shift_step;
                        zero_q    <= (shift_step == '0);
                        ovf_q     <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule
